gmii_idelay_tuner: RTL and testbench

//  Runtime tap controller for GMII RX IDELAYE2 lanes in VAR_LOAD mode; replaces fixed compile-time data taps.

---
 rtl/gmii_tune_pkg.sv | 19 +
 rtl/gmii_tap_window.sv | 42 ++++
 rtl/gmii_idelay_tuner.sv | 169 ++++++++++++++++
 tb/tb_gmii_idelay_tuner.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/gmii_tune_pkg.sv
// Shared types for the GMII RX IDELAY tap tuner.
// State encoding and default tap geometry.
package gmii_tune_pkg;
  localparam int TAP_BITS = 5;
  localparam int TAP_MAX  = 2**TAP_BITS - 1;

  typedef logic [TAP_BITS-1:0] tap_t;

  typedef enum logic [2:0] {
    S_WAIT_RDY,
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_DWELL,
    S_SCORE,
    S_PICK,
    S_APPLY
  } state_t;
endpackage

// File: rtl/gmii_tap_window.sv
// Tracks the current passing run and the longest run seen so far.
// Ties keep the earlier (lower-tap) window.
module gmii_tap_window #(
  parameter int TAP_BITS = 5
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_clear,
  input  logic                i_step,
  input  logic                i_pass,
  input  logic [TAP_BITS-1:0] i_tap,
  output logic [TAP_BITS:0]   o_best_len,
  output logic [TAP_BITS-1:0] o_best_start
);
  logic [TAP_BITS:0]   r_run;
  logic [TAP_BITS:0]   r_best;
  logic [TAP_BITS-1:0] r_start;
  logic [TAP_BITS:0]   w_run_nx;

  assign w_run_nx = r_run + 1'b1;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_run   <= '0;
      r_best  <= '0;
      r_start <= '0;
    end else if (i_step) begin
      if (i_pass) begin
        r_run <= w_run_nx;
        if (w_run_nx > r_best) begin
          r_best  <= w_run_nx;
          r_start <= i_tap - r_run[TAP_BITS-1:0];
        end
      end else begin
        r_run <= '0;
      end
    end
  end

  assign o_best_len   = r_best;
  assign o_best_start = r_start;
endmodule

// File: rtl/gmii_idelay_tuner.sv
// Runtime IDELAYE2 tap controller for the GMII RX data lanes.
// Sweeps taps, scores MAC frame results, applies the best window centre.
module gmii_idelay_tuner
  import gmii_tune_pkg::*;
#(
  parameter int TAP_BITS       = 5,
  parameter int DEFAULT_TAP    = 25,
  parameter int DWELL_FRAMES   = 16,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 2**20,
  parameter int MIN_WINDOW     = 4
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_idelayctrl_rdy,
  input  logic                i_cal_start,
  input  logic                i_man_we,
  input  logic [TAP_BITS-1:0] i_man_tap,
  input  logic                i_frame_good,
  input  logic                i_frame_bad,
  output logic [TAP_BITS-1:0] o_tap_value,
  output logic                o_tap_ld,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_cal_fail,
  output logic [TAP_BITS-1:0] o_win_start,
  output logic [TAP_BITS:0]   o_win_len
);
  localparam int TM = 2**TAP_BITS - 1;
  localparam int FW = $clog2(DWELL_FRAMES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int LW = TAP_BITS + 1;
  localparam logic [TAP_BITS-1:0] DEF = TAP_BITS'(DEFAULT_TAP);

  state_t              r_state, w_next;
  logic [TAP_BITS-1:0] r_tap;
  logic                r_man_ld, r_done, r_fail;
  logic [FW-1:0]       r_good, r_bad;
  logic [TW-1:0]       r_timer;
  logic [SW-1:0]       r_settle;
  logic [TAP_BITS-1:0] r_win_start;
  logic [LW-1:0]       r_win_len;

  logic [FW:0]         w_sum;
  logic                w_abort, w_frames_done, w_timeout;
  logic                w_pass, w_last, w_cal_go, w_man_go, w_ok;
  logic [LW-1:0]       w_best_len, w_half;
  logic [TAP_BITS-1:0] w_best_start, w_mid;

  assign w_abort = !i_idelayctrl_rdy &&
                   r_state != S_WAIT_RDY && r_state != S_IDLE;
  assign w_sum = {1'b0, r_good} + {1'b0, r_bad};
  assign w_frames_done = w_sum >= (FW+1)'(DWELL_FRAMES);
  assign w_timeout = r_timer == TW'(TIMEOUT_CYCLES);
  assign w_pass = r_bad == '0 && r_good >= FW'(DWELL_FRAMES) && !w_timeout;
  assign w_last = r_tap == TAP_BITS'(TM);
  assign w_cal_go = r_state == S_IDLE && i_cal_start;
  assign w_man_go = r_state == S_IDLE && i_man_we && !i_cal_start;
  assign w_ok = w_best_len >= LW'(MIN_WINDOW);
  assign w_half = (w_best_len - 1'b1) >> 1;
  assign w_mid = w_best_start + w_half[TAP_BITS-1:0];

  gmii_tap_window #(.TAP_BITS(TAP_BITS)) u_window (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_clear      (w_cal_go),
    .i_step       (r_state == S_SCORE),
    .i_pass       (w_pass),
    .i_tap        (r_tap),
    .o_best_len   (w_best_len),
    .o_best_start (w_best_start)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= S_WAIT_RDY;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = S_WAIT_RDY;
    end else begin
      unique case (r_state)
        S_WAIT_RDY: if (i_idelayctrl_rdy) w_next = S_APPLY;
        S_IDLE:     if (i_cal_start) w_next = S_LOAD;
        S_LOAD:     w_next = S_SETTLE;
        S_SETTLE:   if (r_settle == SW'(SETTLE_CYCLES - 1)) w_next = S_DWELL;
        S_DWELL:    if (w_frames_done || w_timeout) w_next = S_SCORE;
        S_SCORE:    w_next = w_last ? S_PICK : S_LOAD;
        S_PICK:     w_next = S_APPLY;
        S_APPLY:    w_next = S_IDLE;
        default:    w_next = S_WAIT_RDY;
      endcase
    end
  end

  always_comb begin
    o_tap_ld = r_man_ld;
    o_busy   = 1'b1;
    if (r_state == S_LOAD || r_state == S_APPLY) o_tap_ld = 1'b1;
    if (r_state == S_IDLE) o_busy = 1'b0;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_tap       <= DEF;
      r_man_ld    <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_good      <= '0;
      r_bad       <= '0;
      r_timer     <= '0;
      r_settle    <= '0;
      r_win_start <= '0;
      r_win_len   <= '0;
    end else begin
      r_man_ld <= w_man_go;
      if (w_abort) begin
        r_tap  <= DEF;
        r_done <= 1'b1;
        r_fail <= 1'b1;
      end else begin
        unique case (r_state)
          S_WAIT_RDY: r_tap <= DEF;
          S_IDLE: begin
            if (i_cal_start) begin
              r_tap  <= '0;
              r_done <= 1'b0;
              r_fail <= 1'b0;
            end else if (i_man_we) begin
              r_tap <= i_man_tap;
            end
          end
          S_LOAD: r_settle <= '0;
          S_SETTLE: begin
            r_settle <= r_settle + 1'b1;
            r_good   <= '0;
            r_bad    <= '0;
            r_timer  <= '0;
          end
          S_DWELL: begin
            if (!w_timeout) r_timer <= r_timer + 1'b1;
            if (i_frame_good && r_good != FW'(DWELL_FRAMES))
              r_good <= r_good + 1'b1;
            if (i_frame_bad && r_bad != FW'(DWELL_FRAMES))
              r_bad <= r_bad + 1'b1;
          end
          S_SCORE: if (!w_last) r_tap <= r_tap + 1'b1;
          S_PICK: begin
            r_tap       <= w_ok ? w_mid : DEF;
            r_fail      <= !w_ok;
            r_done      <= 1'b1;
            r_win_start <= w_best_start;
            r_win_len   <= w_best_len;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_tap_value = r_tap;
  assign o_done      = r_done;
  assign o_cal_fail  = r_fail;
  assign o_win_start = r_win_start;
  assign o_win_len   = r_win_len;
endmodule

// File: tb/tb_gmii_idelay_tuner.sv
// Directed bench for gmii_idelay_tuner: reset load, manual load,
// window selection, tie/min-window, timeouts and rdy abort.
module tb_gmii_idelay_tuner;
  logic       clk = 0;
  logic       rst = 1, rdy = 0, cal_start = 0, man_we = 0;
  logic [4:0] man_tap = 0;
  logic       fg = 0, fb = 0;
  logic [4:0] tap, ws, tap5, ws5;
  logic [5:0] wl, wl5;
  logic       ld, busy, done, fail, ld5, busy5, done5, fail5;

  int checks = 0, errors = 0;
  int cyc = 0, ld_cnt = 0, last_ld_cyc = 0, ld_period = 0, cur_tap = 0;
  int mode = 0;
  logic [31:0] mask = 0;

  gmii_idelay_tuner #(.TIMEOUT_CYCLES(64)) dut (
    .i_clock(clk), .i_reset(rst), .i_idelayctrl_rdy(rdy),
    .i_cal_start(cal_start), .i_man_we(man_we), .i_man_tap(man_tap),
    .i_frame_good(fg), .i_frame_bad(fb),
    .o_tap_value(tap), .o_tap_ld(ld), .o_busy(busy), .o_done(done),
    .o_cal_fail(fail), .o_win_start(ws), .o_win_len(wl));

  gmii_idelay_tuner #(.TIMEOUT_CYCLES(64), .MIN_WINDOW(5)) dut5 (
    .i_clock(clk), .i_reset(rst), .i_idelayctrl_rdy(rdy),
    .i_cal_start(cal_start), .i_man_we(man_we), .i_man_tap(man_tap),
    .i_frame_good(fg), .i_frame_bad(fb),
    .o_tap_value(tap5), .o_tap_ld(ld5), .o_busy(busy5), .o_done(done5),
    .o_cal_fail(fail5), .o_win_start(ws5), .o_win_len(wl5));

  always #4 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ld) begin
      ld_cnt      <= ld_cnt + 1;
      ld_period   <= cyc - last_ld_cyc;
      last_ld_cyc <= cyc;
      cur_tap     <= int'(tap);
    end
  end

  // Channel model: mode 1 = good on masked taps else bad, mode 2 = both.
  always @(negedge clk) begin
    fg <= (mode == 1 && mask[cur_tap[4:0]]) || mode == 2;
    fb <= (mode == 1 && !mask[cur_tap[4:0]]) || mode == 2;
  end

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL wait_idle: busy still %0d after %0d cycles, want 0", busy, limit);
    end
  endtask

  task automatic start_cal(input int m, input logic [31:0] msk);
    mode = m;
    mask = msk;
    @(negedge clk);
    cal_start = 1;
    @(negedge clk);
    cal_start = 0;
  endtask

  task automatic test_reset;
    rst = 1; rdy = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    checks++; if (tap !== 5'd25) begin errors++; $display("FAIL rst_tap got %0d want 25", tap); end
    checks++; if (ld !== 1'b0) begin errors++; $display("FAIL rst_ld got %0d want 0", ld); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %0d want 1", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %0d want 0", done); end
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL rst_fail got %0d want 0", fail); end
    checks++; if (ws !== 5'd0) begin errors++; $display("FAIL rst_ws got %0d want 0", ws); end
    checks++; if (wl !== 6'd0) begin errors++; $display("FAIL rst_wl got %0d want 0", wl); end
    man_we = 1; man_tap = 7;
    @(negedge clk);
    man_we = 0;
    @(negedge clk);
    checks++; if (ld_cnt !== 0) begin errors++; $display("FAIL busy_man_ld got %0d loads want 0", ld_cnt); end
    checks++; if (tap !== 5'd25) begin errors++; $display("FAIL busy_man_tap got %0d want 25", tap); end
    while (cyc < 10) @(negedge clk);
    rdy = 1;
    @(negedge clk);
    checks++; if (ld !== 1'b1 || tap !== 5'd25) begin errors++; $display("FAIL init_ld ld=%0d tap=%0d want 1/25", ld, tap); end
    @(negedge clk);
    checks++; if (ld !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL init_end ld=%0d busy=%0d want 0/0", ld, busy); end
    repeat (20) @(negedge clk);
    checks++; if (ld_cnt !== 1) begin errors++; $display("FAIL init_count got %0d loads want 1", ld_cnt); end
  endtask

  task automatic test_manual;
    int n;
    n = ld_cnt;
    man_we = 1; man_tap = 7;
    @(negedge clk);
    man_we = 0;
    checks++; if (ld !== 1'b1 || tap !== 5'd7) begin errors++; $display("FAIL man_ld ld=%0d tap=%0d want 1/7", ld, tap); end
    @(negedge clk);
    checks++; if (ld !== 1'b0) begin errors++; $display("FAIL man_ld_off got %0d want 0", ld); end
    checks++; if (ld_cnt !== n + 1) begin errors++; $display("FAIL man_count got %0d want %0d", ld_cnt, n + 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL man_busy got %0d want 0", busy); end
  endtask

  task automatic test_window;
    mode = 1;
    mask = 32'h000F_FC00;
    @(negedge clk);
    cal_start = 1; man_we = 1; man_tap = 7;
    @(negedge clk);
    cal_start = 0; man_we = 0;
    checks++; if (ld !== 1'b1 || tap !== 5'd0) begin errors++; $display("FAIL cal_first ld=%0d tap=%0d want 1/0", ld, tap); end
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL cal_flags busy=%0d done=%0d want 1/0", busy, done); end
    wait_idle(3000);
    checks++; if (ws !== 5'd10) begin errors++; $display("FAIL win_start got %0d want 10", ws); end
    checks++; if (wl !== 6'd10) begin errors++; $display("FAIL win_len got %0d want 10", wl); end
    checks++; if (tap !== 5'd14) begin errors++; $display("FAIL win_tap got %0d want 14", tap); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL win_done got %0d want 1", done); end
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL win_fail got %0d want 0", fail); end
  endtask

  task automatic test_tie;
    start_cal(1, 32'h00F0_0078);
    wait_idle(3000);
    checks++; if (ws !== 5'd3) begin errors++; $display("FAIL tie_start got %0d want 3", ws); end
    checks++; if (wl !== 6'd4) begin errors++; $display("FAIL tie_len got %0d want 4", wl); end
    checks++; if (tap !== 5'd4) begin errors++; $display("FAIL tie_tap got %0d want 4", tap); end
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL tie_fail got %0d want 0", fail); end
    checks++; if (tap5 !== 5'd25) begin errors++; $display("FAIL min5_tap got %0d want 25", tap5); end
    checks++; if (fail5 !== 1'b1) begin errors++; $display("FAIL min5_fail got %0d want 1", fail5); end
    checks++; if (wl5 !== 6'd4 || ws5 !== 5'd3) begin errors++; $display("FAIL min5_win len=%0d start=%0d want 4/3", wl5, ws5); end
    checks++; if (done5 !== 1'b1 || busy5 !== 1'b0) begin errors++; $display("FAIL min5_flags done=%0d busy=%0d want 1/0", done5, busy5); end
  endtask

  task automatic test_timeout;
    start_cal(0, 32'h0);
    wait_idle(6000);
    checks++; if (wl !== 6'd0) begin errors++; $display("FAIL to_len got %0d want 0", wl); end
    checks++; if (fail !== 1'b1) begin errors++; $display("FAIL to_fail got %0d want 1", fail); end
    checks++; if (tap !== 5'd25) begin errors++; $display("FAIL to_tap got %0d want 25", tap); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL to_done got %0d want 1", done); end
  endtask

  task automatic test_abort;
    int n;
    start_cal(2, 32'h0);
    checks++; if (done !== 1'b0 || fail !== 1'b0) begin errors++; $display("FAIL ab_clear done=%0d fail=%0d want 0/0", done, fail); end
    n = 0;
    while (cur_tap != 12 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++; if (cur_tap != 12) begin errors++; $display("FAIL ab_reach tap %0d want 12", cur_tap); end
    // 1 load + 16 settle + 9 dwell (2 frames/cycle) + 1 score
    checks++; if (ld_period !== 27) begin errors++; $display("FAIL ab_period got %0d want 27", ld_period); end
    repeat (5) @(negedge clk);
    rdy = 0;
    @(negedge clk);
    checks++; if (done !== 1'b1 || fail !== 1'b1) begin errors++; $display("FAIL ab_flags done=%0d fail=%0d want 1/1", done, fail); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ab_busy got %0d want 1", busy); end
    repeat (5) @(negedge clk);
    n = ld_cnt;
    rdy = 1;
    wait_idle(100);
    repeat (10) @(negedge clk);
    checks++; if (ld_cnt !== n + 1) begin errors++; $display("FAIL ab_reload got %0d loads want %0d", ld_cnt, n + 1); end
    checks++; if (tap !== 5'd25) begin errors++; $display("FAIL ab_tap got %0d want 25", tap); end
  endtask

  initial begin
    test_reset;
    test_manual;
    test_window;
    test_tie;
    test_timeout;
    test_abort;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
